uart_cmd_arbiter: RTL and testbench
===================================

Name: uart_cmd_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single UART command engine between NUM_REQ requesters. It grants one requester at a time and issues that requester's 16-bit command to the engine, where cmd bit 15 = 1 means write and 0 means read. It then waits for the engine to finish, routes read data back to the owner, and times out on a hung transfer. Sits between the host-side command sources and the UART engine's cmd_in/cmd_vld/cmd_rdy/read_rdy/read_data interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CMD_WIDTH, 16, command width; MSB is the write/read flag
READ_WIDTH, 8, read data width
TIMEOUT, 100000, cycles allowed in WAIT_ACC+WAIT_DONE before abort (fits in 17-bit counter)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_cmd  in  NUM_REQ*CMD_WIDTH  requester i command at [i*CMD_WIDTH +: CMD_WIDTH]
req_vld  in  NUM_REQ  command valid per requester
req_rdy  out  NUM_REQ  accept, one-hot, combinational
rsp_vld  out  NUM_REQ  one-cycle completion pulse to owner
rsp_data  out  READ_WIDTH  read data, valid with rsp_vld
rsp_err  out  1  timeout flag, valid with rsp_vld
uart_cmd  out  CMD_WIDTH  command to engine
uart_cmd_vld  out  1  command valid to engine
uart_cmd_rdy  in  1  engine idle/ready
uart_read_rdy  in  1  engine read-data strobe
uart_read_data  in  READ_WIDTH  engine read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Single clock clk; reset is asynchronous, active-low (rst_n). All registered outputs clear on reset.
- Reset values: state=IDLE, uart_cmd=0, uart_cmd_vld=0, rsp_vld=0, rsp_data=0, rsp_err=0, last_gnt=NUM_REQ-1 (so req 0 wins first), timer=0.
- Arbitration (IDLE only):
  - Search req_vld starting at last_gnt+1, wrapping mod NUM_REQ; first set bit wins.
  - req_rdy[g]=1 combinationally in that cycle only; other bits are 0.
  - On req_vld[g]&&req_rdy[g]: latch cmd_buf=req_cmd[g], owner=g, last_gnt=g; go to ISSUE.
- FSM:
  - IDLE: arbitration as above. No valid request -> stay.
  - ISSUE: uart_cmd=cmd_buf, uart_cmd_vld=1. If uart_cmd_rdy=1 this cycle -> WAIT_ACC.
  - WAIT_ACC: uart_cmd_vld held at 1. When uart_cmd_rdy=0 (engine took the command) -> deassert uart_cmd_vld, go to WAIT_DONE.
  - WAIT_DONE, write (cmd_buf[MSB]=1): uart_cmd_rdy returning to 1 -> RESP with rsp_data=0, rsp_err=0.
  - WAIT_DONE, read (cmd_buf[MSB]=0): uart_read_rdy=1 -> capture uart_read_data into rsp_data, rsp_err=0 -> RESP.
  - RESP: rsp_vld[owner]=1 for exactly one cycle -> IDLE.
- Timer:
  - Clears on entry to ISSUE; increments in WAIT_ACC and WAIT_DONE.
  - timer==TIMEOUT-1 -> RESP with rsp_err=1, rsp_data=0, uart_cmd_vld=0.
- Latency: grant to uart_cmd_vld = 1 cycle. Completion event to rsp_vld = 1 cycle. Back-to-back grants are separated by at least one IDLE cycle.
- Boundary conditions:
  - Completion event and timeout in the same cycle: the completion wins and rsp_err=0.
  - uart_read_rdy outside WAIT_DONE-read is ignored; no rsp_vld is generated.
  - A requester dropping req_vld after acceptance has no effect; the transfer completes.
  - req_vld changes while not IDLE are ignored; requesters hold req_vld until req_rdy.
  - last_gnt wraps from NUM_REQ-1 to 0.
  - rst_n low mid-transfer: immediate return to IDLE; uart_cmd_vld drops asynchronously; no rsp_vld is issued.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE, ISSUE, WAIT_ACC, WAIT_DONE, RESP), CMD_WR_BIT index (CMD_WIDTH-1), default CMD_WIDTH/READ_WIDTH.
- Sub-module rr_arbiter: combinational grant from req vector and last_gnt. Outputs a one-hot grant and a binary index (width clog2(NUM_REQ)).

Test Plan:
- Reset, then req_vld=4'b0001 with req_cmd0=16'h8A55 (write); engine model drops cmd_rdy 2 cycles after vld and raises it 30 cycles later -> uart_cmd=16'h8A55, then rsp_vld=4'b0001 with rsp_err=0 one cycle after cmd_rdy rises.
- Read: req2 cmd=16'h0012; engine pulses read_rdy with data 8'hC3 -> rsp_vld=4'b0100, rsp_data=8'hC3, rsp_err=0.
- Fairness: all four req_vld held continuously -> grant order 0,1,2,3,0; req_rdy is one-hot each time and no requester is starved.
- Timeout: TIMEOUT=64, engine never drops cmd_rdy after ISSUE -> rsp_vld[owner] pulses with rsp_err=1, uart_cmd_vld=0, busy falls next cycle.
- Collision: read_rdy asserted on the same cycle the timer reaches TIMEOUT-1 -> rsp_err=0, rsp_data=captured value.
- Reset mid-read in WAIT_DONE -> busy=0 and uart_cmd_vld=0 immediately; no rsp_vld; after release, req 0 is granted first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command arbiter: sequencer state encoding,
// default widths and the write-flag bit position helper.
package uart_pkg;

    localparam int CMD_WIDTH_DEF  = 16;
    localparam int READ_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 100000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACC  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    // The write/read flag is always the command MSB.
    function automatic int cmd_wr_bit(input int cmd_width);
        return cmd_width - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_gnt, wrapping,
// returned both one-hot and as a binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Shares one UART command engine among NUM_REQ requesters: round-robin grant,
// command issue, completion wait with timeout, and response routing.
//
//   state     | meaning
//   IDLE      | arbitrate; accept the granted requester's command
//   ISSUE     | present command, wait for engine ready
//   WAIT_ACC  | command held until engine drops ready (taken)
//   WAIT_DONE | wait for write done (ready back) or read data strobe
//   RESP      | one-cycle rsp_vld pulse to the owner
module uart_cmd_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CMD_WIDTH  = CMD_WIDTH_DEF,
    parameter int READ_WIDTH = READ_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_cmd,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [READ_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [CMD_WIDTH-1:0]          uart_cmd,
    output logic                          uart_cmd_vld,
    input  logic                          uart_cmd_rdy,
    input  logic                          uart_read_rdy,
    input  logic [READ_WIDTH-1:0]         uart_read_data,
    output logic                          busy
);

    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int TMR_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int CMD_WR_BIT = cmd_wr_bit(CMD_WIDTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [CMD_WIDTH-1:0]   uart_cmd_q, uart_cmd_d;
    logic                   uart_cmd_vld_q, uart_cmd_vld_d;
    logic [NUM_REQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [READ_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    logic [NUM_REQ-1:0]     gnt;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   done_evt;
    logic                   timed_out;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req      (req_vld),
        .last_gnt (last_gnt_q),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    assign req_rdy = (state_q == IDLE) ? gnt : '0;

    always_comb begin
        state_d        = state_q;
        uart_cmd_d     = uart_cmd_q;
        uart_cmd_vld_d = uart_cmd_vld_q;
        rsp_vld_d      = '0;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        last_gnt_d     = last_gnt_q;
        owner_d        = owner_q;
        timer_d        = timer_q;
        timed_out      = (timer_q == TMR_LAST);
        done_evt       = uart_cmd_q[CMD_WR_BIT] ? uart_cmd_rdy : uart_read_rdy;

        unique case (state_q)
            IDLE: begin
                if (|req_rdy) begin
                    uart_cmd_d     = req_cmd[int'(gnt_idx)*CMD_WIDTH +: CMD_WIDTH];
                    uart_cmd_vld_d = 1'b1;
                    owner_d        = gnt_idx;
                    last_gnt_d     = gnt_idx;
                    timer_d        = '0;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                uart_cmd_vld_d = 1'b1;
                if (uart_cmd_rdy) state_d = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (timed_out) begin
                    uart_cmd_vld_d = 1'b0;
                    rsp_vld_d      = NUM_REQ'(1) << owner_q;
                    rsp_data_d     = '0;
                    rsp_err_d      = 1'b1;
                    state_d        = RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (!uart_cmd_rdy) begin
                        uart_cmd_vld_d = 1'b0;
                        state_d        = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // A completion seen on the last allowed cycle still counts as success.
                if (done_evt) begin
                    rsp_vld_d  = NUM_REQ'(1) << owner_q;
                    rsp_data_d = uart_cmd_q[CMD_WR_BIT] ? '0 : uart_read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (timed_out) begin
                    uart_cmd_vld_d = 1'b0;
                    rsp_vld_d      = NUM_REQ'(1) << owner_q;
                    rsp_data_d     = '0;
                    rsp_err_d      = 1'b1;
                    state_d        = RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            uart_cmd_q     <= '0;
            uart_cmd_vld_q <= 1'b0;
            rsp_vld_q      <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            last_gnt_q     <= IDX_W'(NUM_REQ - 1);
            owner_q        <= '0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            uart_cmd_q     <= uart_cmd_d;
            uart_cmd_vld_q <= uart_cmd_vld_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            last_gnt_q     <= last_gnt_d;
            owner_q        <= owner_d;
            timer_q        <= timer_d;
        end
    end

    assign uart_cmd     = uart_cmd_q;
    assign uart_cmd_vld = uart_cmd_vld_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Scoreboard bench for uart_cmd_arbiter: requesters, a behavioural UART engine,
// and a monitor that predicts grants and responses from the arbitration rules.
module tb_uart_cmd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CW      = 16;
    localparam int RW      = 8;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ*CW-1:0] req_cmd;
    logic [NUM_REQ-1:0]    req_vld;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [NUM_REQ-1:0]    rsp_vld;
    logic [RW-1:0]         rsp_data;
    logic                  rsp_err;
    logic [CW-1:0]         uart_cmd;
    logic                  uart_cmd_vld;
    logic                  uart_cmd_rdy;
    logic                  uart_read_rdy;
    logic [RW-1:0]         uart_read_data;
    logic                  busy;

    logic [CW-1:0] cmds [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd
        assign req_cmd[gi*CW +: CW] = cmds[gi];
    end

    uart_cmd_arbiter #(
        .NUM_REQ(NUM_REQ), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_cmd(req_cmd), .req_vld(req_vld),
        .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .uart_cmd(uart_cmd), .uart_cmd_vld(uart_cmd_vld),
        .uart_cmd_rdy(uart_cmd_rdy), .uart_read_rdy(uart_read_rdy),
        .uart_read_data(uart_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { int owner; logic [RW-1:0] data; logic err; } exp_t;
    exp_t exp_q[$];

    // Engine behaviour knobs set by stimulus; per-transaction values by the monitor.
    int          lat_lo = 1, lat_hi = 1;
    bit          eng_hang = 0;
    bit          data_fix_en = 0;
    logic [RW-1:0] data_fix = '0;
    int          eng_lat = 1;
    logic [RW-1:0] eng_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Engine: takes the command 2 cycles after seeing it, finishes eng_lat later.
    initial begin
        logic [CW-1:0] c;
        uart_cmd_rdy = 1'b1; uart_read_rdy = 1'b0; uart_read_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && uart_cmd_vld) begin
                c = uart_cmd;
                if (eng_hang) begin
                    while (uart_cmd_vld) @(negedge clk);
                end else begin
                    repeat (2) @(posedge clk);
                    #1 uart_cmd_rdy = 1'b0;
                    repeat (eng_lat) @(posedge clk);
                    #1;
                    if (c[CW-1]) begin
                        uart_cmd_rdy = 1'b1;
                    end else begin
                        uart_read_data = eng_data;
                        uart_read_rdy  = 1'b1;
                        @(posedge clk);
                        #1 uart_read_rdy = 1'b0;
                        uart_cmd_rdy = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int mdl_last = NUM_REQ - 1;
        bit mdl_busy = 0;
        bit cmd_chk = 0;
        logic [CW-1:0] cmd_exp = '0;
        int g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdl_last = NUM_REQ - 1;
                mdl_busy = 0;
                cmd_chk  = 0;
                exp_q.delete();
            end else begin
                check("busy", 32'(busy), 32'(mdl_busy));
                if (cmd_chk) begin
                    check("uart_cmd_vld_issue", 32'(uart_cmd_vld), 32'd1);
                    check("uart_cmd", 32'(uart_cmd), 32'(cmd_exp));
                    cmd_chk = 0;
                end
                if (rsp_vld != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp_vld", 32'(rsp_vld), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_vld", 32'(rsp_vld), 32'(1) << e.owner);
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("uart_cmd_vld_resp", 32'(uart_cmd_vld), 32'd0);
                    end
                    mdl_busy = 0;
                end else if (!mdl_busy) begin
                    g = pick(req_vld, mdl_last);
                    if (req_vld != '0)
                        check("req_rdy", 32'(req_rdy), (g < 0) ? 32'd0 : (32'(1) << g));
                    if (g >= 0) begin
                        mdl_last = g;
                        mdl_busy = 1;
                        eng_lat  = $urandom_range(lat_hi, lat_lo);
                        eng_data = data_fix_en ? data_fix : RW'($urandom);
                        e.owner  = g;
                        e.err    = eng_hang || (eng_lat + 1 > TIMEOUT - 1);
                        e.data   = (e.err || cmds[g][CW-1]) ? '0 : eng_data;
                        exp_q.push_back(e);
                        cmd_exp  = cmds[g];
                        cmd_chk  = 1;
                    end
                end else if (req_vld != '0) begin
                    check("req_rdy_busy", 32'(req_rdy), 32'd0);
                end
            end
        end
    end

    task automatic serve(input int budget, input int rearm);
        logic [NUM_REQ-1:0] acc;
        bit done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            acc = req_vld & req_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    if (rearm > 0) begin
                        rearm--;
                        cmds[i] = CW'($urandom);
                    end else begin
                        req_vld[i] = 1'b0;
                    end
                end
            end
            done = (req_vld == '0) && !busy && (exp_q.size() == 0);
        end
        check("serve_done", 32'(done), 32'd1);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) cmds[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_uart_cmd_vld", 32'(uart_cmd_vld), 32'd0);
        check("rst_uart_cmd", 32'(uart_cmd), 32'd0);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write from req 0, engine completes 30 cycles after taking it.
        cmds[0] = 16'h8A55; lat_lo = 30; lat_hi = 30;
        req_vld = 4'b0001;
        serve(200, 0);

        // Read from req 2 returning C3.
        cmds[2] = 16'h0012; data_fix_en = 1; data_fix = 8'hC3; lat_lo = 5; lat_hi = 5;
        req_vld = 4'b0100;
        serve(200, 0);
        data_fix_en = 0;

        // Fairness: all four held, each re-armed after acceptance.
        for (int i = 0; i < NUM_REQ; i++) cmds[i] = CW'($urandom);
        lat_lo = 1; lat_hi = 20;
        req_vld = 4'b1111;
        serve(3000, 5);

        // Hung engine: never takes the command.
        eng_hang = 1; cmds[1] = CW'($urandom);
        req_vld = 4'b0010;
        serve(300, 0);
        eng_hang = 0;

        // Read completing on the last allowed cycle, then one cycle too late.
        cmds[3] = 16'h0044; data_fix_en = 1; data_fix = 8'hA7;
        lat_lo = TIMEOUT - 2; lat_hi = TIMEOUT - 2;
        req_vld = 4'b1000;
        serve(300, 0);
        lat_lo = TIMEOUT - 1; lat_hi = TIMEOUT - 1;
        req_vld = 4'b1000;
        serve(300, 0);
        cmds[0] = 16'h9001;
        req_vld = 4'b0001;
        serve(300, 0);
        data_fix_en = 0;

        // Random mixes of requesters, commands and latencies.
        lat_lo = 1; lat_hi = 66;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NUM_REQ; i++) cmds[i] = CW'($urandom);
            req_vld = NUM_REQ'($urandom_range(15, 1));
            serve(2000, 0);
        end

        // Reset in the middle of a read's WAIT_DONE.
        cmds[0] = 16'h0033; lat_lo = 40; lat_hi = 40;
        req_vld = 4'b0001;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_vld[0] && req_rdy[0]) begin
                @(posedge clk); #1 req_vld = '0; ok = 1;
            end
        end
        check("rstmid_accept", 32'(ok), 32'd1);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = busy && !uart_cmd_vld;
        end
        check("rstmid_wait_done", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_uart_cmd_vld", 32'(uart_cmd_vld), 32'd0);
        check("rstmid_rsp_vld", 32'(rsp_vld), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        cmds[0] = 16'h8123; cmds[1] = 16'h0456; lat_lo = 5; lat_hi = 5;
        req_vld = 4'b0011;
        serve(400, 0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
